// File: rtl/queue_port_ctrl.sv
// Bus-side controller in front of the 8-bit queue: arbitrates a write stream and a read stream
// onto the shared tri-state io bus. Optional QPORT_RR_ARB_EN: round-robin tie-break in IDLE.
module queue_port_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BURST_MAX = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   inout  wire  [DATA_W-1:0] io,
   output logic              en,
   output logic              rw,
   input  logic              empty,
   input  logic              full,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy
);

   localparam int unsigned      CNT_W     = 8;
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] HIT_AT    = CNT_W'(BURST_MAX - 1);

   typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             turn_wr, turn_wr_nxt;
   logic             want_wr, want_rd, slot_free;
   logic             push, pop, drive, cnt_hit, tie_wr;

   assign want_wr   = wr_valid & ~full;
   assign slot_free = ~rd_valid | rd_ready;
   assign want_rd   = ~empty & slot_free;
   assign cnt_hit   = (cnt >= HIT_AT);
   assign busy      = (state != IDLE);
   assign io        = drive ? wr_data : {DATA_W{1'bz}};

`ifdef QPORT_RR_ARB_EN
   logic last_rd;

   // Remembers which direction was served most recently; starts as "read" so writes win first.
   always_ff @(posedge clk) begin
      if (!reset_n)           last_rd <= 1'b1;
      else if (state == WR)   last_rd <= 1'b0;
      else if (state == RD)   last_rd <= 1'b1;
   end

   assign tie_wr = last_rd;
`else
   assign tie_wr = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         turn_wr <= 1'b0;
      end else begin
         state   <= state_nxt;
         turn_wr <= turn_wr_nxt;
      end
   end

   // Next-state and bus strobes.
   always_comb begin
      state_nxt   = state;
      turn_wr_nxt = turn_wr;
      en          = 1'b0;
      rw          = 1'b1;
      wr_ready    = 1'b0;
      drive       = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (want_wr && want_rd) state_nxt = tie_wr ? WR : RD;
            else if (want_wr)       state_nxt = WR;
            else if (want_rd)       state_nxt = RD;
         end
         WR: begin
            rw       = 1'b0;
            drive    = 1'b1;
            wr_ready = ~full;
            push     = want_wr;
            en       = want_wr;
            if (!want_wr || (cnt_hit && want_rd)) begin
               turn_wr_nxt = 1'b0;
               state_nxt   = want_rd ? TURN : IDLE;
            end
         end
         RD: begin
            rw  = 1'b1;
            pop = want_rd;
            en  = want_rd;
            if (!want_rd || (cnt_hit && want_wr)) begin
               turn_wr_nxt = 1'b1;
               state_nxt   = want_wr ? TURN : IDLE;
            end
         end
         TURN: begin
            rw = ~turn_wr;
            if (turn_wr ? want_wr : want_rd) state_nxt = turn_wr ? WR : RD;
            else                             state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A strobe raised during reset would commit a transfer the reset is meant to abandon.
      if (!reset_n) begin
         en       = 1'b0;
         wr_ready = 1'b0;
         push     = 1'b0;
         pop      = 1'b0;
      end
   end

   // Burst length: restarts on every state change, saturates at the limit.
   always_comb begin
      cnt_nxt = cnt;
      if (state_nxt != state)                    cnt_nxt = '0;
      else if ((push || pop) && cnt != BURST_LIM) cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt_nxt;
   end

   // One-byte read buffer; a pop on the hand-off edge keeps it full with the new byte.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (pop) begin
         rd_data  <= io;
         rd_valid <= 1'b1;
      end else if (rd_ready) begin
         rd_valid <= 1'b0;
      end
   end

   a_no_push_full:  assert property (@(posedge clk) disable iff (!reset_n) !(en && !rw && full));
   a_no_pop_empty:  assert property (@(posedge clk) disable iff (!reset_n) !(en && rw && empty));
   a_no_drive_rd:   assert property (@(posedge clk) disable iff (!reset_n) !(drive && rw));
   a_turn_quiet:    assert property (@(posedge clk) disable iff (!reset_n) (state == TURN) |-> !en);

endmodule

// File: tb/tb_queue_port_ctrl.sv
// Self-checking bench for queue_port_ctrl: behavioural queue on io, end-to-end byte scoreboard,
// directed scenarios followed by randomized traffic.
module tb_queue_port_ctrl;

   localparam int unsigned DW  = 8;
   localparam int unsigned BM  = 4;
   localparam int unsigned CAP = 1024;

   logic          clk = 1'b0;
   logic          reset_n;
   wire  [DW-1:0] io;
   logic          en, rw, empty, full, wr_valid, wr_ready, rd_valid, rd_ready, busy;
   logic [DW-1:0] wr_data, rd_data, q_head;
   logic          force_full;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic [7:0] ref_out[$];

   logic          p_en, p_rw, p_wv, p_wr, p_rv, p_rr, p_busy, p_full, p_empty, p_rst;
   logic [DW-1:0] p_io, p_wd, p_rd;

   always #5 clk = ~clk;

   assign io = (en && rw) ? q_head : {DW{1'bz}};

   queue_port_ctrl #(.DATA_W(DW), .BURST_MAX(BM)) dut (
      .clk(clk), .reset_n(reset_n), .io(io), .en(en), .rw(rw),
      .empty(empty), .full(full), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      empty  = (q.size() == 0);
      full   = force_full || (q.size() >= int'(CAP));
      q_head = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic preload(input logic [7:0] b);
      q.push_back(b);
      ref_out.push_back(b);
      refresh();
   endtask

   // One clock: sample before the edge, advance, then apply queue/consumer effects and check.
   task automatic step();
      logic [7:0] popped;
      logic       exp_rv;
      logic [7:0] exp_rd;
      popped = 8'h00;
      #2;
      p_en = en; p_rw = rw; p_io = io; p_wv = wr_valid; p_wr = wr_ready; p_wd = wr_data;
      p_rv = rd_valid; p_rr = rd_ready; p_rd = rd_data; p_busy = busy;
      p_full = full; p_empty = empty; p_rst = reset_n;
      if (p_rst) begin
         check("handshake_vs_push", 32'(p_wv && p_wr), 32'(p_en && !p_rw));
         if (p_en && !p_rw) check("push_byte", 32'(p_io), 32'(p_wd));
         if (p_en) check("strobe_legal", 32'(p_rw ? p_empty : p_full), 32'(0));
         if (p_rw && p_en)  check("io_queue_head", 32'(p_io), 32'(q_head));
         if (p_rw && !p_en) check("io_released", 32'(p_io === p_wd), 32'(0));
      end
      @(posedge clk);
      #1;
      if (p_rst) begin
         if (p_wv && p_wr) ref_out.push_back(p_wd);
         if (p_en && !p_rw) q.push_back(p_io);
         if (p_en && p_rw && q.size() != 0) popped = q.pop_front();
         if (p_rv && p_rr) begin
            if (ref_out.size() == 0) check("take_unexpected", 32'(1), 32'(0));
            else                     check("take_data", 32'(p_rd), 32'(ref_out.pop_front()));
         end
         exp_rv = (p_en && p_rw) ? 1'b1 : (p_rv && !p_rr);
         exp_rd = (p_en && p_rw) ? popped : p_rd;
         check("rd_valid", 32'(rd_valid), 32'(exp_rv));
         check("rd_data", 32'(rd_data), 32'(exp_rd));
         if (!p_busy) begin
            if (p_wv && !p_full) begin
               check("arb_wr_busy", 32'(busy), 32'(1));
               check("arb_wr_dir", 32'(rw), 32'(0));
            end else if (!p_empty && (!p_rv || p_rr)) begin
               check("arb_rd_busy", 32'(busy), 32'(1));
               check("arb_rd_dir", 32'(rw), 32'(1));
            end else begin
               check("arb_stay_idle", 32'(busy), 32'(0));
            end
         end
      end else begin
         ref_out = q;
         check("rst_busy", 32'(busy), 32'(0));
         check("rst_en", 32'(en), 32'(0));
         check("rst_rw", 32'(rw), 32'(1));
         check("rst_rd_valid", 32'(rd_valid), 32'(0));
         check("rst_rd_data", 32'(rd_data), 32'(0));
      end
      refresh();
   endtask

   task automatic drain();
      int n;
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      force_full = 1'b0;
      refresh();
      n = 0;
      while (n < 2500 && (q.size() != 0 || rd_valid || busy)) begin
         step();
         n++;
      end
      check("drain_done", 32'(q.size() != 0 || rd_valid || busy), 32'(0));
      check("scoreboard_empty", 32'(ref_out.size()), 32'(0));
   endtask

   initial begin
      reset_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h01; force_full = 1'b0;
      refresh();
      step();
      step();

      // One byte parked in the read buffer with the consumer stalled.
      reset_n = 1'b1;
      preload(8'hEE);
      step();
      step();
      check("park_pop_data", 32'(rd_data), 32'hEE);
      step();
      check("park_idle", 32'(busy), 32'(0));

      // Five back-to-back pushes.
      wr_valid = 1'b1; wr_data = 8'h01;
      step();
      for (int i = 1; i <= 5; i++) begin
         wr_data = 8'(i);
         step();
         check("push_en", 32'(p_en), 32'(1));
         check("push_rw", 32'(p_rw), 32'(0));
         check("push_io", 32'(p_io), 32'(i));
         check("push_ready", 32'(p_wr), 32'(1));
      end
      wr_valid = 1'b0;
      step();
      check("push_done_idle", 32'(busy), 32'(0));

      // Stalled consumer: no pop, buffer holds.
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_no_pop", 32'(p_en), 32'(0));
         check("stall_hold", 32'(rd_data), 32'hEE);
      end
      rd_ready = 1'b1;
      step();
      for (int i = 1; i <= 5; i++) begin
         step();
         check("stream_pop", 32'(p_en && p_rw), 32'(1));
         check("stream_data", 32'(rd_data), 32'(i));
         check("stream_valid", 32'(rd_valid), 32'(1));
      end
      step();
      check("stream_idle", 32'(busy), 32'(0));
      check("stream_drained", 32'(rd_valid), 32'(0));

      // Two queued bytes popped on consecutive edges.
      preload(8'hA0);
      preload(8'hA1);
      step();
      step();
      check("a0_data", 32'(rd_data), 32'hA0);
      step();
      check("a1_pop", 32'(p_en), 32'(1));
      check("a1_data", 32'(rd_data), 32'hA1);
      step();
      check("a_empty", 32'(empty), 32'(1));
      check("a_idle", 32'(busy), 32'(0));

      // Full queue blocks the producer until it drops.
      rd_ready = 1'b0; force_full = 1'b1; refresh();
      wr_valid = 1'b1; wr_data = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         step();
         check("full_no_en", 32'(p_en), 32'(0));
         check("full_no_ready", 32'(p_wr), 32'(0));
      end
      force_full = 1'b0; refresh();
      step();
      step();
      check("unfull_push", 32'(p_en && !p_rw), 32'(1));
      check("unfull_io", 32'(p_io), 32'h5A);
      wr_valid = 1'b0;
      step();
      check("unfull_once", 32'(p_en && !p_rw), 32'(0));
      drain();

      // Both sides saturated: bursts of BM separated by single turnaround cycles.
      for (int i = 0; i < 10; i++) preload(8'(8'hB0 + i));
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'($urandom_range(1, 255));
      step();
      for (int k = 0; k < 14; k++) begin
         int ph;
         ph = k % 5;
         wr_data = 8'($urandom_range(1, 255));
         step();
         if (ph < 4) begin
            check("burst_en", 32'(p_en), 32'(1));
            check("burst_rw", 32'(p_rw), 32'(((k / 5) % 2 == 0) ? 0 : 1));
         end else begin
            check("turn_en", 32'(p_en), 32'(0));
            check("turn_rw", 32'(p_rw), 32'(((k / 5) % 2 == 0) ? 1 : 0));
            check("turn_busy", 32'(p_busy), 32'(1));
            check("turn_io_released", 32'(p_io === p_wd), 32'(0));
         end
      end
      drain();

      // Reset in the middle of a write burst.
      rd_ready = 1'b0; wr_valid = 1'b1; wr_data = 8'h31;
      step();
      step();
      wr_data = 8'h32;
      step();
      reset_n = 1'b0; wr_data = 8'h33;
      step();
      check("rst_mid_no_en", 32'(p_en), 32'(0));
      check("rst_mid_no_ready", 32'(p_wr), 32'(0));
      step();
      check("rst_hold_no_en", 32'(p_en), 32'(0));
      check("rst_pushes_kept", 32'(q.size()), 32'(2));
      reset_n = 1'b1;
      drain();

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 1500; i++) begin
         wr_valid   = ($urandom_range(0, 3) != 0);
         wr_data    = 8'($urandom_range(1, 255));
         rd_ready   = 1'($urandom_range(0, 1));
         force_full = ($urandom_range(0, 9) == 0);
         refresh();
         step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/queue_port_ctrl.md
Name: queue_port_ctrl

Overview:
- Bus-side controller placed directly in front of the 8-bit, 1024-deep `queue` block.
- Converts one producer valid/ready write stream and one consumer valid/ready read stream into the queue's single shared tri-state `io` bus and its `en`/`rw` strobes.
- Arbitrates between writes and reads, inserts bus turnaround cycles, and buffers one read byte.

Parameters:
- DATA_W, 8, width of `io`, write data and read data.
- BURST_MAX, 16, maximum consecutive transfers in one direction while the other direction is waiting; range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- io  inout  DATA_W  shared bus to queue.io.
- en  output  1  queue strobe; the queue acts on the rising edge where en=1.
- rw  output  1  0 = write (controller drives io), 1 = read (queue drives io).
- empty  input  1  from queue.
- full  input  1  from queue.
- wr_data  input  DATA_W  producer byte.
- wr_valid  input  1  producer has a byte.
- wr_ready  output  1  byte accepted on this edge when wr_valid=1.
- rd_data  output  DATA_W  registered byte popped from the queue.
- rd_valid  output  1  rd_data holds a byte.
- rd_ready  input  1  consumer takes rd_data on this edge.
- busy  output  1  state != IDLE.

Behaviour:
- Queue bus contract:
  - Queue drives io only while en=1 and rw=1; its head byte is valid on io in that cycle.
  - Pop and push happen on the edge where en=1.
- Reset (reset_n=0 at a rising edge, any state):
  - state=IDLE, en=0, rw=1, io=Z, wr_ready=0, rd_valid=0, rd_data=0, burst counter=0.
  - A transfer in flight is abandoned; no partial push or pop is committed.
- Request terms:
  - want_wr = wr_valid & ~full
  - slot_free = ~rd_valid | rd_ready
  - want_rd = ~empty & slot_free
- FSM states: IDLE, WR, RD, TURN.
  - IDLE:
    - want_wr goes to WR; else want_rd goes to RD; else stay.
    - Write wins ties (see Optional Feature).
    - en=0, io=Z.
  - WR:
    - rw=0; io=wr_data.
    - wr_ready = ~full; en = wr_valid & ~full.
    - Each push increments the burst counter.
    - Leave when ~want_wr, or when the counter reaches BURST_MAX and want_rd=1.
    - Exit goes to TURN if want_rd=1, else to IDLE.
  - RD:
    - rw=1; io released.
    - en = want_rd.
    - On the edge with en=1: rd_data <= io, rd_valid <= 1; burst counter increments.
    - Leave when ~want_rd, or when the counter reaches BURST_MAX and want_wr=1.
    - Exit goes to TURN if want_wr=1, else to IDLE.
  - TURN:
    - Exactly one cycle: en=0, io=Z, rw already at the new direction value.
    - Then enter the pending direction if its request is still true, else IDLE.
- Burst counter: cleared on every state change.
- rd_valid:
  - Clears on rd_valid & rd_ready unless a new pop occurs on the same edge; in that case it stays 1 with the new data.
- en is never 1 while full=1 with rw=0, or while empty=1 with rw=1.
- rw never changes in a cycle where en=1.
- The controller never drives io while rw=1.
- Throughput: one byte per clock in a sustained single-direction burst. A direction switch costs exactly one TURN cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: QPORT_RR_ARB_EN.
- Defined:
  - IDLE ties go to the direction not served last (one-bit last_dir register).
  - last_dir resets to 1 (read last), so the first tie goes to write.
- Undefined:
  - Fixed write priority in IDLE.
  - The BURST_MAX limit still applies in both variants.

Test Plan:
- Reset then push 0x01..0x05 with wr_valid=1, full=0:
  - Five consecutive en=1, rw=0 cycles with io=0x01..0x05.
  - wr_ready high on each of those edges.
- Queue model full=1 while wr_valid=1:
  - en=0 and wr_ready=0 until full drops.
  - Then the held byte is pushed exactly once.
- Queue holds 0xA0, 0xA1; rd_ready=1:
  - Two pops on consecutive edges.
  - rd_data=0xA0 then 0xA1, each with rd_valid=1.
  - empty=1 afterwards, leading to IDLE.
- Both sides busy, BURST_MAX=4:
  - Sequence is 4 writes, TURN (en=0, io=Z), 4 reads, TURN, and so on.
  - No cycle has the controller driving io while rw=1.
- rd_ready=0 with rd_valid=1, queue non-empty:
  - No pop; rd_data holds its value.
  - Raising rd_ready gives pop and hand-off on the same edge.
- reset_n=0 mid-burst after 2 of 5 writes:
  - On the next edge en=0, io=Z, state IDLE, rd_valid=0.
  - No further push until reset_n=1.
